// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath widths, ALU operation classes and the
// decode-to-execute control bundle with its bubble encoding.
package rv32i_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   // Operation class produced by the main decoder, refined by alu_controller
   typedef enum logic [2:0] {
      ALU_OP_LOAD_STORE = 3'd0,
      ALU_OP_BRANCH     = 3'd1,
      ALU_OP_R_TYPE     = 3'd2,
      ALU_OP_I_TYPE     = 3'd3,
      ALU_OP_LUI        = 3'd4,
      ALU_OP_AUIPC      = 3'd5,
      ALU_OP_JUMP       = 3'd6,
      ALU_OP_NONE       = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic        valid;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic [2:0]  func_3;
      logic        func_7_bit_6;
      alu_op_e     alu_operations_selector;
   } id_ex_ctrl_t;

   localparam id_ex_ctrl_t BUBBLE = '{
      valid                   : 1'b0,
      mem_read                : 1'b0,
      mem_write               : 1'b0,
      reg_write               : 1'b0,
      func_3                  : 3'b000,
      func_7_bit_6            : 1'b0,
      alu_operations_selector : ALU_OP_LOAD_STORE
   };

endpackage

// File: rtl/load_use_hazard_unit.sv
// Combinational load-use detector: a valid load in EX whose non-zero rd is
// read by the valid instruction currently in decode.
module load_use_hazard_unit #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  ex_valid,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr,
   input  logic                  id_valid,
   input  logic                  id_uses_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   output logic                  hazard
);

   logic load_in_ex_s;
   logic rs1_match_s;
   logic rs2_match_s;

   // Compare decode source registers against the destination of the load in EX
   always_comb begin
      load_in_ex_s = ex_valid & ex_mem_read & (ex_rd_addr != {REG_ADDR_W{1'b0}});
      rs1_match_s  = id_uses_rs1 & (id_rs1_addr == ex_rd_addr);
      rs2_match_s  = id_uses_rs2 & (id_rs2_addr == ex_rd_addr);
      hazard       = load_in_ex_s & id_valid & (rs1_match_s | rs2_match_s);
   end

endmodule

// File: rtl/id_ex_pipeline_register.sv
// Decode-to-execute pipeline register with load-use interlock and a
// saturating counter of the bubbles the interlock inserts.
module id_ex_pipeline_register #(
   parameter int XLEN       = rv32i_pkg::XLEN,
   parameter int REG_ADDR_W = rv32i_pkg::REG_ADDR_W,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [XLEN-1:0]       id_pc,
   input  logic [XLEN-1:0]       id_rs1_data,
   input  logic [XLEN-1:0]       id_rs2_data,
   input  logic [XLEN-1:0]       id_imm,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic [REG_ADDR_W-1:0] id_rd_addr,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [2:0]            id_func_3,
   input  logic                  id_func_7_bit_6,
   input  logic [2:0]            id_alu_operations_selector,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic                  id_reg_write,
   input  logic                  ex_flush,
   input  logic                  ex_stall_in,
   input  logic                  bubble_count_clr,
   output logic                  load_use_stall,
   output logic                  ex_valid,
   output logic [XLEN-1:0]       ex_pc,
   output logic [XLEN-1:0]       ex_rs1_data,
   output logic [XLEN-1:0]       ex_rs2_data,
   output logic [XLEN-1:0]       ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rs1_addr,
   output logic [REG_ADDR_W-1:0] ex_rs2_addr,
   output logic [REG_ADDR_W-1:0] ex_rd_addr,
   output logic [2:0]            ex_func_3,
   output logic                  ex_func_7_bit_6,
   output logic [2:0]            ex_alu_operations_selector,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_reg_write,
   output logic [CNT_W-1:0]      bubble_count
);

   import rv32i_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [XLEN-1:0]  X_ZERO   = {XLEN{1'b0}};
   localparam logic [REG_ADDR_W-1:0] A_ZERO = {REG_ADDR_W{1'b0}};

   id_ex_ctrl_t           ctrl_r, ctrl_n_s;
   logic [XLEN-1:0]       pc_r, pc_n_s;
   logic [XLEN-1:0]       rs1_data_r, rs1_data_n_s;
   logic [XLEN-1:0]       rs2_data_r, rs2_data_n_s;
   logic [XLEN-1:0]       imm_r, imm_n_s;
   logic [REG_ADDR_W-1:0] rs1_addr_r, rs1_addr_n_s;
   logic [REG_ADDR_W-1:0] rs2_addr_r, rs2_addr_n_s;
   logic [REG_ADDR_W-1:0] rd_addr_r, rd_addr_n_s;
   logic [CNT_W-1:0]      cnt_r, cnt_n_s;
   logic                  hazard_s;
   logic                  insert_bubble_s;

   load_use_hazard_unit #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard (
      .ex_valid    (ctrl_r.valid),
      .ex_mem_read (ctrl_r.mem_read),
      .ex_rd_addr  (rd_addr_r),
      .id_valid    (id_valid),
      .id_uses_rs1 (id_uses_rs1),
      .id_rs1_addr (id_rs1_addr),
      .id_uses_rs2 (id_uses_rs2),
      .id_rs2_addr (id_rs2_addr),
      .hazard      (hazard_s)
   );

   // A flush already kills the consumer, so no front-end hold is requested then
   always_comb begin
      load_use_stall  = hazard_s & ~ex_flush;
      insert_bubble_s = hazard_s & ~ex_flush & ~ex_stall_in;
   end

   // Next-state selection: stall holds, flush or hazard bubbles, else capture
   always_comb begin
      ctrl_n_s     = ctrl_r;
      pc_n_s       = pc_r;
      rs1_data_n_s = rs1_data_r;
      rs2_data_n_s = rs2_data_r;
      imm_n_s      = imm_r;
      rs1_addr_n_s = rs1_addr_r;
      rs2_addr_n_s = rs2_addr_r;
      rd_addr_n_s  = rd_addr_r;
      if (ex_stall_in) begin
         ctrl_n_s = ctrl_r;
      end else if (ex_flush || hazard_s) begin
         ctrl_n_s     = BUBBLE;
         pc_n_s       = X_ZERO;
         rs1_data_n_s = X_ZERO;
         rs2_data_n_s = X_ZERO;
         imm_n_s      = X_ZERO;
         rs1_addr_n_s = A_ZERO;
         rs2_addr_n_s = A_ZERO;
         rd_addr_n_s  = A_ZERO;
      end else begin
         // Side-effecting controls are gated so an empty slot never commits
         ctrl_n_s.valid                   = id_valid;
         ctrl_n_s.mem_read                = id_mem_read & id_valid;
         ctrl_n_s.mem_write               = id_mem_write & id_valid;
         ctrl_n_s.reg_write               = id_reg_write & id_valid;
         ctrl_n_s.func_3                  = id_func_3;
         ctrl_n_s.func_7_bit_6            = id_func_7_bit_6;
         ctrl_n_s.alu_operations_selector = alu_op_e'(id_alu_operations_selector);
         pc_n_s       = id_pc;
         rs1_data_n_s = id_rs1_data;
         rs2_data_n_s = id_rs2_data;
         imm_n_s      = id_imm;
         rs1_addr_n_s = id_rs1_addr;
         rs2_addr_n_s = id_rs2_addr;
         rd_addr_n_s  = id_rd_addr;
      end
   end

   // Bubble counter: clear wins, otherwise saturating increment per bubble
   always_comb begin
      cnt_n_s = cnt_r;
      if (bubble_count_clr) begin
         cnt_n_s = CNT_ZERO;
      end else if (insert_bubble_s && (cnt_r != CNT_MAX)) begin
         cnt_n_s = cnt_r + CNT_ONE;
      end else begin
         cnt_n_s = cnt_r;
      end
   end

   // Pipeline state and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_r     <= BUBBLE;
         pc_r       <= X_ZERO;
         rs1_data_r <= X_ZERO;
         rs2_data_r <= X_ZERO;
         imm_r      <= X_ZERO;
         rs1_addr_r <= A_ZERO;
         rs2_addr_r <= A_ZERO;
         rd_addr_r  <= A_ZERO;
         cnt_r      <= CNT_ZERO;
      end else begin
         ctrl_r     <= ctrl_n_s;
         pc_r       <= pc_n_s;
         rs1_data_r <= rs1_data_n_s;
         rs2_data_r <= rs2_data_n_s;
         imm_r      <= imm_n_s;
         rs1_addr_r <= rs1_addr_n_s;
         rs2_addr_r <= rs2_addr_n_s;
         rd_addr_r  <= rd_addr_n_s;
         cnt_r      <= cnt_n_s;
      end
   end

   assign ex_valid                   = ctrl_r.valid;
   assign ex_mem_read                = ctrl_r.mem_read;
   assign ex_mem_write               = ctrl_r.mem_write;
   assign ex_reg_write               = ctrl_r.reg_write;
   assign ex_func_3                  = ctrl_r.func_3;
   assign ex_func_7_bit_6            = ctrl_r.func_7_bit_6;
   assign ex_alu_operations_selector = ctrl_r.alu_operations_selector;
   assign ex_pc                      = pc_r;
   assign ex_rs1_data                = rs1_data_r;
   assign ex_rs2_data                = rs2_data_r;
   assign ex_imm                     = imm_r;
   assign ex_rs1_addr                = rs1_addr_r;
   assign ex_rs2_addr                = rs2_addr_r;
   assign ex_rd_addr                 = rd_addr_r;
   assign bubble_count               = cnt_r;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed bench for id_ex_pipeline_register; a second CNT_W=4 instance
// shares all inputs so its counter can be driven into saturation.
module tb_id_ex_pipeline_register;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic        id_uses_rs1, id_uses_rs2;
   logic [2:0]  id_func_3;
   logic        id_func_7_bit_6;
   logic [2:0]  id_alu_operations_selector;
   logic        id_mem_read, id_mem_write, id_reg_write;
   logic        ex_flush, ex_stall_in, bubble_count_clr;

   logic        load_use_stall, ex_valid;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
   logic [2:0]  ex_func_3, ex_alu_operations_selector;
   logic        ex_func_7_bit_6, ex_mem_read, ex_mem_write, ex_reg_write;
   logic [31:0] bubble_count;

   logic        s_load_use_stall, s_ex_valid;
   logic [31:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
   logic [4:0]  s_ex_rs1_addr, s_ex_rs2_addr, s_ex_rd_addr;
   logic [2:0]  s_ex_func_3, s_ex_alu_operations_selector;
   logic        s_ex_func_7_bit_6, s_ex_mem_read, s_ex_mem_write, s_ex_reg_write;
   logic [3:0]  s_bubble_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_ex_pipeline_register dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_func_3(id_func_3),
      .id_func_7_bit_6(id_func_7_bit_6), .id_alu_operations_selector(id_alu_operations_selector),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
      .ex_flush(ex_flush), .ex_stall_in(ex_stall_in), .bubble_count_clr(bubble_count_clr),
      .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
      .ex_func_3(ex_func_3), .ex_func_7_bit_6(ex_func_7_bit_6),
      .ex_alu_operations_selector(ex_alu_operations_selector), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .bubble_count(bubble_count)
   );

   id_ex_pipeline_register #(.CNT_W(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_func_3(id_func_3),
      .id_func_7_bit_6(id_func_7_bit_6), .id_alu_operations_selector(id_alu_operations_selector),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
      .ex_flush(ex_flush), .ex_stall_in(ex_stall_in), .bubble_count_clr(bubble_count_clr),
      .load_use_stall(s_load_use_stall), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc),
      .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm),
      .ex_rs1_addr(s_ex_rs1_addr), .ex_rs2_addr(s_ex_rs2_addr), .ex_rd_addr(s_ex_rd_addr),
      .ex_func_3(s_ex_func_3), .ex_func_7_bit_6(s_ex_func_7_bit_6),
      .ex_alu_operations_selector(s_ex_alu_operations_selector), .ex_mem_read(s_ex_mem_read),
      .ex_mem_write(s_ex_mem_write), .ex_reg_write(s_ex_reg_write), .bubble_count(s_bubble_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop();
      id_valid = 1'b1; id_pc = 32'h0; id_rs1_data = 32'h0; id_rs2_data = 32'h0;
      id_imm = 32'h0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rd_addr = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_func_3 = 3'd0; id_func_7_bit_6 = 1'b0;
      id_alu_operations_selector = 3'd0; id_mem_read = 1'b0; id_mem_write = 1'b0;
      id_reg_write = 1'b0; ex_flush = 1'b0; ex_stall_in = 1'b0; bubble_count_clr = 1'b0;
   endtask

   task automatic drive_load(input logic [4:0] rd);
      set_nop();
      id_pc = 32'h0000_1000; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd_addr = rd;
      id_uses_rs1 = 1'b1; id_rs1_addr = 5'd2;
   endtask

   task automatic drive_consumer(input logic [4:0] rs, input logic use_rs1, input logic use_rs2);
      set_nop();
      id_pc = 32'h0000_1004; id_reg_write = 1'b1; id_rd_addr = 5'd9;
      id_rs1_addr = rs; id_rs2_addr = rs; id_uses_rs1 = use_rs1; id_uses_rs2 = use_rs2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_nop();
      id_pc = $urandom(); id_rs1_data = $urandom(); id_rs2_data = $urandom();
      id_imm = $urandom(); id_rd_addr = 5'($urandom()); id_mem_write = 1'b1;
      id_reg_write = 1'b1; id_mem_read = 1'b1; id_func_3 = 3'($urandom());
      tick(); tick();
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got=%0h want=0", ex_valid); end
      checks++; if (ex_pc !== 32'h0) begin errors++; $display("FAIL reset_ex_pc got=%0h want=0", ex_pc); end
      checks++; if ({ex_rs1_data, ex_rs2_data, ex_imm} !== 96'h0) begin errors++; $display("FAIL reset_ex_data got=%0h want=0", {ex_rs1_data, ex_rs2_data, ex_imm}); end
      checks++; if ({ex_rd_addr, ex_func_3, ex_mem_read, ex_mem_write, ex_reg_write} !== 11'h0) begin errors++; $display("FAIL reset_ex_ctrl got=%0h want=0", {ex_rd_addr, ex_func_3, ex_mem_read, ex_mem_write, ex_reg_write}); end
      checks++; if (bubble_count !== 32'd0) begin errors++; $display("FAIL reset_bubble_count got=%0d want=0", bubble_count); end
      set_nop();
      id_pc = 32'h0000_0040;
      rst_n = 1'b1;
      tick();
      checks++; if (ex_pc !== 32'h0000_0040) begin errors++; $display("FAIL reset_first_capture got=%0h want=40", ex_pc); end
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid got=%0h want=1", ex_valid); end
   endtask

   task automatic test_pass_through();
      set_nop();
      id_pc = 32'h0000_0100; id_rs1_data = 32'h1111_1111; id_rs2_data = 32'h2222_2222;
      id_imm = 32'hFFFF_FFF0; id_rs1_addr = 5'd1; id_rs2_addr = 5'd2; id_rd_addr = 5'd3;
      id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_func_3 = 3'b101; id_func_7_bit_6 = 1'b1;
      id_alu_operations_selector = 3'd2; id_reg_write = 1'b1;
      #1;
      checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL pass_stall got=%0h want=0", load_use_stall); end
      tick();
      checks++; if ({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm} !== {32'h100, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFF0}) begin
         errors++; $display("FAIL pass_data got=%0h want=%0h", {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm}, {32'h100, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFF0}); end
      checks++; if ({ex_rs1_addr, ex_rs2_addr, ex_rd_addr} !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL pass_addr got=%0h want=%0h", {ex_rs1_addr, ex_rs2_addr, ex_rd_addr}, {5'd1, 5'd2, 5'd3}); end
      checks++; if ({ex_func_3, ex_func_7_bit_6, ex_alu_operations_selector} !== {3'b101, 1'b1, 3'd2}) begin errors++; $display("FAIL pass_func got=%0h want=%0h", {ex_func_3, ex_func_7_bit_6, ex_alu_operations_selector}, {3'b101, 1'b1, 3'd2}); end
      checks++; if ({ex_valid, ex_mem_read, ex_mem_write, ex_reg_write} !== 4'b1001) begin errors++; $display("FAIL pass_ctrl got=%0b want=1001", {ex_valid, ex_mem_read, ex_mem_write, ex_reg_write}); end
   endtask

   task automatic test_load_use();
      drive_load(5'd5); tick();
      drive_consumer(5'd5, 1'b0, 1'b1); #1;
      checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0h want=1", load_use_stall); end
      tick();
      checks++; if ({ex_valid, ex_reg_write, ex_pc} !== {1'b0, 1'b0, 32'h0}) begin errors++; $display("FAIL lu_bubble got=%0h want=0", {ex_valid, ex_reg_write, ex_pc}); end
      checks++; if (bubble_count !== 32'd1) begin errors++; $display("FAIL lu_count got=%0d want=1", bubble_count); end
      checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_one_cycle got=%0h want=0", load_use_stall); end
      tick();
      checks++; if ({ex_valid, ex_rd_addr, ex_pc} !== {1'b1, 5'd9, 32'h1004}) begin errors++; $display("FAIL lu_resume got=%0h want=%0h", {ex_valid, ex_rd_addr, ex_pc}, {1'b1, 5'd9, 32'h1004}); end
      drive_load(5'd0); tick();
      drive_consumer(5'd0, 1'b0, 1'b1); #1;
      checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_rd0_stall got=%0h want=0", load_use_stall); end
      tick();
      checks++; if ({ex_valid, bubble_count} !== {1'b1, 32'd1}) begin errors++; $display("FAIL lu_rd0_capture got=%0h want=%0h", {ex_valid, bubble_count}, {1'b1, 32'd1}); end
      drive_load(5'd5); tick();
      drive_consumer(5'd5, 1'b0, 1'b0); #1;
      checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_nouse_stall got=%0h want=0", load_use_stall); end
      tick();
      checks++; if ({ex_valid, bubble_count} !== {1'b1, 32'd1}) begin errors++; $display("FAIL lu_nouse_capture got=%0h want=%0h", {ex_valid, bubble_count}, {1'b1, 32'd1}); end
   endtask

   task automatic test_stall();
      set_nop(); id_pc = 32'h0000_0200; id_rd_addr = 5'd4; tick();
      for (int i = 0; i < 3; i++) begin
         ex_stall_in = 1'b1; id_pc = 32'h300 + 32'(i * 4); id_rd_addr = 5'(10 + i);
         tick();
         checks++; if ({ex_pc, ex_rd_addr} !== {32'h200, 5'd4}) begin errors++; $display("FAIL stall_hold%0d got=%0h want=%0h", i, {ex_pc, ex_rd_addr}, {32'h200, 5'd4}); end
      end
      ex_stall_in = 1'b0; id_pc = 32'h0000_0400; tick();
      checks++; if (ex_pc !== 32'h400) begin errors++; $display("FAIL stall_release got=%0h want=400", ex_pc); end
      drive_load(5'd7); tick();
      drive_consumer(5'd7, 1'b1, 1'b0); ex_stall_in = 1'b1; #1;
      checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL stall_hazard_stall got=%0h want=1", load_use_stall); end
      tick();
      checks++; if ({ex_mem_read, ex_rd_addr, bubble_count} !== {1'b1, 5'd7, 32'd1}) begin errors++; $display("FAIL stall_hazard_hold got=%0h want=%0h", {ex_mem_read, ex_rd_addr, bubble_count}, {1'b1, 5'd7, 32'd1}); end
      ex_stall_in = 1'b0; tick();
      checks++; if ({ex_valid, bubble_count} !== {1'b0, 32'd2}) begin errors++; $display("FAIL stall_hazard_release got=%0h want=%0h", {ex_valid, bubble_count}, {1'b0, 32'd2}); end
   endtask

   task automatic test_flush();
      drive_load(5'd8); tick();
      drive_consumer(5'd8, 1'b1, 1'b0); ex_flush = 1'b1; #1;
      checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%0h want=0", load_use_stall); end
      tick();
      checks++; if ({ex_valid, ex_mem_read, ex_reg_write, ex_pc, bubble_count} !== {3'b000, 32'h0, 32'd2}) begin errors++; $display("FAIL flush_bubble got=%0h want=%0h", {ex_valid, ex_mem_read, ex_reg_write, ex_pc, bubble_count}, {3'b000, 32'h0, 32'd2}); end
      set_nop(); id_pc = 32'h0000_0500; id_reg_write = 1'b1; tick();
      ex_flush = 1'b1; ex_stall_in = 1'b1; id_pc = 32'h0000_0504; tick();
      checks++; if ({ex_valid, ex_reg_write, ex_pc} !== {2'b11, 32'h500}) begin errors++; $display("FAIL flush_under_stall got=%0h want=%0h", {ex_valid, ex_reg_write, ex_pc}, {2'b11, 32'h500}); end
      set_nop(); id_valid = 1'b0; id_pc = 32'h0000_0600; id_mem_write = 1'b1; id_reg_write = 1'b1; id_mem_read = 1'b1; tick();
      checks++; if ({ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_pc} !== {4'b0000, 32'h600}) begin errors++; $display("FAIL invalid_slot got=%0h want=%0h", {ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_pc}, {4'b0000, 32'h600}); end
   endtask

   task automatic test_counter();
      set_nop(); bubble_count_clr = 1'b1; tick();
      checks++; if ({bubble_count, s_bubble_count} !== {32'd0, 4'd0}) begin errors++; $display("FAIL cnt_clear got=%0h want=0", {bubble_count, s_bubble_count}); end
      for (int i = 0; i < 20; i++) begin
         drive_load(5'd3); tick();
         drive_consumer(5'd3, 1'b1, 1'b1); tick();
         if (i == 14) begin
            checks++; if (s_bubble_count !== 4'd15) begin errors++; $display("FAIL cnt_reach_max got=%0d want=15", s_bubble_count); end
         end
      end
      checks++; if (s_bubble_count !== 4'd15) begin errors++; $display("FAIL cnt_saturate got=%0d want=15", s_bubble_count); end
      checks++; if (bubble_count !== 32'd20) begin errors++; $display("FAIL cnt_wide got=%0d want=20", bubble_count); end
      drive_load(5'd3); tick();
      drive_consumer(5'd3, 1'b1, 1'b0); bubble_count_clr = 1'b1; tick();
      checks++; if ({bubble_count, s_bubble_count, ex_valid} !== {32'd0, 4'd0, 1'b0}) begin errors++; $display("FAIL cnt_clr_wins got=%0h want=0", {bubble_count, s_bubble_count, ex_valid}); end
   endtask

   task automatic test_async_reset();
      set_nop(); id_pc = 32'h0000_0700; id_reg_write = 1'b1; tick();
      drive_load(5'd3); tick();
      drive_consumer(5'd3, 1'b1, 1'b0); tick();
      #2 rst_n = 1'b0; #1;
      checks++; if ({ex_valid, ex_pc, ex_reg_write, bubble_count} !== {1'b0, 32'h0, 1'b0, 32'd0}) begin errors++; $display("FAIL async_reset got=%0h want=0", {ex_valid, ex_pc, ex_reg_write, bubble_count}); end
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_load_use();
      test_stall();
      test_flush();
      test_counter();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
